// File: rtl/ram_even_odd_pkg.sv
// ram_even_odd_pkg: shared widths, types and lifting constants for the
// even/odd sample store used by the 5/3 integer lifting wavelet datapath.
// Optional build macro: LIFT_SAT_EN (saturate lift results instead of wrapping).
package ram_even_odd_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 9;
  localparam int SIDE_W = 10;
  localparam int DEPTH  = 2**ADDR_W;

  // Neighbour sum carries one extra bit; lifting arithmetic runs at 12 bits
  // so that x +/- step can never overflow before narrowing.
  localparam int SUM_W  = SIDE_W + 1;
  localparam int LIFT_W = 12;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [SIDE_W-1:0] side_t;
  typedef logic        [ADDR_W-1:0] addr_t;
  typedef logic signed [LIFT_W-1:0] lift_t;

  // Lifting target select and direction encodings as seen on the ports.
  localparam logic LIFT_PREDICT = 1'b1;
  localparam logic LIFT_UPDATE  = 1'b0;
  localparam logic DIR_FWD      = 1'b1;
  localparam logic DIR_INV      = 1'b0;

  typedef enum logic {
    LIFT_IDLE,
    LIFT_WRITEBACK
  } lift_state_e;

  // Everything captured on the start strobe so the write-back is immune to
  // whatever the sequencer drives on the following cycle.
  typedef struct packed {
    logic  target;
    addr_t addr;
    logic  fwd;
    side_t left;
    side_t right;
  } lift_ctx_t;

`ifdef LIFT_SAT_EN
  localparam int SAMPLE_MAX = 2**(DATA_W-1) - 1;
  localparam int SAMPLE_MIN = -(2**(DATA_W-1));
`endif

  // Narrow a 12-bit lifting result to a stored sample: clamp to the sample
  // range when saturation is built in, otherwise keep the low bits.
  function automatic sample_t narrow_lift(input lift_t y);
`ifdef LIFT_SAT_EN
    if (int'(y) > SAMPLE_MAX) begin
      return sample_t'(SAMPLE_MAX);
    end
    if (int'(y) < SAMPLE_MIN) begin
      return sample_t'(SAMPLE_MIN);
    end
    return sample_t'(y);
`else
    return sample_t'(y);
`endif
  endfunction

endpackage

// File: rtl/ram_even_odd_bank.sv
// ram_bank_1rw: single-port synchronous RAM, read-first, with a registered
// read output that clears on reset. The array itself is never reset.
module ram_bank_1rw
  import ram_even_odd_pkg::*;
#(
  parameter int AW      = ADDR_W,
  parameter int DW      = DATA_W,
  parameter int DEPTH_P = DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [DW-1:0] mem_q [DEPTH_P];
  logic [DW-1:0] dout_q;

  // Storage array: plain synchronous write with no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  // Read register: samples the array before this edge's write lands (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= mem_q[addr_i];
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/ram_even_odd.sv
// ram_even_odd: even/odd sample banks with an in-place 5/3 lifting engine.
// A start strobe latches the lift context and reads the old sample; the next
// edge writes the lifted value back, overriding any host write to that bank.
// Optional build macro: LIFT_SAT_EN (saturate lift results instead of wrapping).
module ram_even_odd
  import ram_even_odd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        pix_addr_even,
  input  logic [DATA_W-1:0]        pix_din_even,
  input  logic                     pix_we_even,
  output logic [DATA_W-1:0]        pix_dout_even,
  input  logic [ADDR_W-1:0]        pix_addr_odd,
  input  logic [DATA_W-1:0]        pix_din_odd,
  input  logic                     pix_we_odd,
  output logic [DATA_W-1:0]        pix_dout_odd,
  input  logic signed [SIDE_W-1:0] pix_left,
  input  logic signed [SIDE_W-1:0] pix_right,
  input  logic                     pix_p,
  input  logic                     pix_even_odd,
  input  logic                     pix_fwd_inv
);

  lift_state_e liftState_q, liftState_d;
  lift_ctx_t   liftCtx_q, liftCtx_d;

  logic                    wbEven, wbOdd;
  logic                    subtract;
  logic signed [SUM_W-1:0] sum;
  sample_t                 xSample, yNarrow;
  lift_t                   x, s, step, y;

  logic [ADDR_W-1:0] bankAddrEven, bankAddrOdd;
  logic [DATA_W-1:0] bankDinEven, bankDinOdd;
  logic              bankWeEven, bankWeOdd;

  // Lift state and latched context; a reset mid-lift simply forgets the lift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      liftState_q <= LIFT_IDLE;
      liftCtx_q   <= '0;
    end else begin
      liftState_q <= liftState_d;
      liftCtx_q   <= liftCtx_d;
    end
  end

  // Next-state: start a lift only from idle, so strobes during write-back are dropped.
  always_comb begin
    liftState_d = liftState_q;
    liftCtx_d   = liftCtx_q;
    case (liftState_q)
      LIFT_IDLE: begin
        if (pix_p) begin
          liftState_d      = LIFT_WRITEBACK;
          liftCtx_d.target = pix_even_odd;
          liftCtx_d.addr   = (pix_even_odd == LIFT_PREDICT) ? pix_addr_odd : pix_addr_even;
          liftCtx_d.fwd    = pix_fwd_inv;
          liftCtx_d.left   = pix_left;
          liftCtx_d.right  = pix_right;
        end
      end
      LIFT_WRITEBACK: begin
        liftState_d = LIFT_IDLE;
      end
      default: begin
        liftState_d = LIFT_IDLE;
      end
    endcase
  end

  // Lifting arithmetic on the old sample now sitting in the target read register.
  always_comb begin
    xSample  = (liftCtx_q.target == LIFT_PREDICT) ? pix_dout_odd : pix_dout_even;
    sum      = {liftCtx_q.left[SIDE_W-1], liftCtx_q.left}
             + {liftCtx_q.right[SIDE_W-1], liftCtx_q.right};
    x        = {{(LIFT_W-DATA_W){xSample[DATA_W-1]}}, xSample};
    s        = {{(LIFT_W-SUM_W){sum[SUM_W-1]}}, sum};
    step     = (liftCtx_q.target == LIFT_PREDICT) ? (s >>> 1) : ((s + lift_t'(2)) >>> 2);
    subtract = (liftCtx_q.target == LIFT_PREDICT) ? (liftCtx_q.fwd == DIR_FWD)
                                                  : (liftCtx_q.fwd == DIR_INV);
    y        = subtract ? (x - step) : (x + step);
    yNarrow  = narrow_lift(y);
  end

  // Bank port steering: the write-back cycle takes over the target bank's port.
  always_comb begin
    wbEven       = (liftState_q == LIFT_WRITEBACK) && (liftCtx_q.target == LIFT_UPDATE);
    wbOdd        = (liftState_q == LIFT_WRITEBACK) && (liftCtx_q.target == LIFT_PREDICT);
    bankAddrEven = wbEven ? liftCtx_q.addr : pix_addr_even;
    bankDinEven  = wbEven ? yNarrow        : pix_din_even;
    bankWeEven   = wbEven | pix_we_even;
    bankAddrOdd  = wbOdd  ? liftCtx_q.addr : pix_addr_odd;
    bankDinOdd   = wbOdd  ? yNarrow        : pix_din_odd;
    bankWeOdd    = wbOdd  | pix_we_odd;
  end

  ram_bank_1rw #(
    .AW      (ADDR_W),
    .DW      (DATA_W),
    .DEPTH_P (DEPTH)
  ) u_bankEven (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (bankAddrEven),
    .we_i   (bankWeEven),
    .din_i  (bankDinEven),
    .dout_o (pix_dout_even)
  );

  ram_bank_1rw #(
    .AW      (ADDR_W),
    .DW      (DATA_W),
    .DEPTH_P (DEPTH)
  ) u_bankOdd (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr_i (bankAddrOdd),
    .we_i   (bankWeOdd),
    .din_i  (bankDinOdd),
    .dout_o (pix_dout_odd)
  );

endmodule

// File: tb/tb_ram_even_odd.sv
// tb_ram_even_odd: directed bench for the even/odd lifting store.
// Optional build macro: LIFT_SAT_EN (changes the expected overflow result).
module tb_ram_even_odd;

  logic              clk;
  logic              rst_n;
  logic [6:0]        pix_addr_even;
  logic [8:0]        pix_din_even;
  logic              pix_we_even;
  logic [8:0]        pix_dout_even;
  logic [6:0]        pix_addr_odd;
  logic [8:0]        pix_din_odd;
  logic              pix_we_odd;
  logic [8:0]        pix_dout_odd;
  logic signed [9:0] pix_left;
  logic signed [9:0] pix_right;
  logic              pix_p;
  logic              pix_even_odd;
  logic              pix_fwd_inv;

  int checks = 0;
  int errors = 0;

`ifdef LIFT_SAT_EN
  localparam logic [8:0] OVF_EXP = 9'd255;
`else
  localparam logic [8:0] OVF_EXP = 9'h1F4;
`endif

  ram_even_odd dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_addr_even (pix_addr_even),
    .pix_din_even  (pix_din_even),
    .pix_we_even   (pix_we_even),
    .pix_dout_even (pix_dout_even),
    .pix_addr_odd  (pix_addr_odd),
    .pix_din_odd   (pix_din_odd),
    .pix_we_odd    (pix_we_odd),
    .pix_dout_odd  (pix_dout_odd),
    .pix_left      (pix_left),
    .pix_right     (pix_right),
    .pix_p         (pix_p),
    .pix_even_odd  (pix_even_odd),
    .pix_fwd_inv   (pix_fwd_inv)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's worth of inputs, then advance to just past the next edge.
  task automatic applyStimulus(
    input logic [6:0] aE, input logic [8:0] dE, input logic wE,
    input logic [6:0] aO, input logic [8:0] dO, input logic wO,
    input logic p, input logic eo, input logic fi,
    input logic [9:0] l, input logic [9:0] r
  );
    pix_addr_even = aE;
    pix_din_even  = dE;
    pix_we_even   = wE;
    pix_addr_odd  = aO;
    pix_din_odd   = dO;
    pix_we_odd    = wO;
    pix_p         = p;
    pix_even_odd  = eo;
    pix_fwd_inv   = fi;
    pix_left      = l;
    pix_right     = r;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
      $error("[TB] check %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    pix_addr_even = '0;
    pix_din_even  = '0;
    pix_we_even   = 1'b0;
    pix_addr_odd  = '0;
    pix_din_odd   = '0;
    pix_we_odd    = 1'b0;
    pix_p         = 1'b0;
    pix_even_odd  = 1'b0;
    pix_fwd_inv   = 1'b0;
    pix_left      = '0;
    pix_right     = '0;

    // Reset state
    #12;
    checkOutput("reset_dout_even", pix_dout_even, 9'd0);
    checkOutput("reset_dout_odd", pix_dout_odd, 9'd0);
    rst_n = 1'b1;

    // Host write then read, with a read-first check on the overwrite edge
    applyStimulus(7'd5, 9'd11, 1'b1, 7'd5, 9'd22, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd5, 9'd100, 1'b1, 7'd5, 9'h1F9, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("readfirst_even", pix_dout_even, 9'd11);
    checkOutput("readfirst_odd", pix_dout_odd, 9'd22);
    applyStimulus(7'd5, 9'd0, 1'b0, 7'd5, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("host_even_100", pix_dout_even, 9'd100);
    checkOutput("host_odd_m7", pix_dout_odd, 9'h1F9);

    // Forward predict on odd[3]=50, l=40 r=20: 50 - 30 = 20; host addr moves in cycle 1
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd3, 9'd50, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd40, 10'd20);
    checkOutput("pred_x_held", pix_dout_odd, 9'd50);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd7, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("pred_fwd", pix_dout_odd, 9'd20);

    // Inverse predict on 20 with the same neighbours: 20 + 30 = 50
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd40, 10'd20);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("pred_inv", pix_dout_odd, 9'd50);

    // Forward update on even[3]=100, l=10 r=7: (17+2)>>>2 = 4, 100 + 4 = 104
    applyStimulus(7'd3, 9'd100, 1'b1, 7'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd3, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd10, 10'd7);
    applyStimulus(7'd3, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd3, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("upd_fwd", pix_dout_even, 9'd104);

    // Inverse update: 104 - 4 = 100
    applyStimulus(7'd3, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd10, 10'd7);
    applyStimulus(7'd3, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd3, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("upd_inv", pix_dout_even, 9'd100);

    // Overflow: odd[0]=200, l=r=-300, d=-300, y=500 -> 255 saturated or -12 wrapped
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd0, 9'd200, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, -10'sd300, -10'sd300);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd0, 9'd0, 1'b0, 7'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("overflow", pix_dout_odd, OVF_EXP);

    // Collision: host writes odd[3]=9 and even[9]=33 in the write-back cycle,
    // plus a second strobe that must be ignored; lift on odd[3]=50 gives 20
    applyStimulus(7'd9, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd40, 10'd20);
    applyStimulus(7'd9, 9'd33, 1'b1, 7'd3, 9'd9, 1'b1, 1'b1, 1'b1, 1'b1, 10'd100, 10'd100);
    applyStimulus(7'd9, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    applyStimulus(7'd9, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("collision_odd", pix_dout_odd, 9'd20);
    checkOutput("other_bank_even", pix_dout_even, 9'd33);

    // Reset during write-back cycle: douts clear at once, odd[3] keeps 20
    applyStimulus(7'd9, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd40, 10'd20);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_even", pix_dout_even, 9'd0);
    checkOutput("midreset_odd", pix_dout_odd, 9'd0);
    pix_p = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(7'd9, 9'd0, 1'b0, 7'd3, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
    checkOutput("midreset_retain", pix_dout_odd, 9'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
